// File: rtl/row_serializer_pkg.sv
// Shared definitions for the row serializer: FSM encoding, default geometry and
// a counter-width helper that stays legal for single-entry dimensions.
package row_serializer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } rs_state_e;

   localparam int ROW_DEF   = 512;
   localparam int COL_DEF   = 512;
   localparam int WIDTH_DEF = 8;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/row_serializer_pixel_select.sv
// Column mux: picks one pixel out of a packed row, column 0 at the MSB end.
module pixel_select
   import row_serializer_pkg::*;
#(
   parameter int ROW   = ROW_DEF,
   parameter int width = WIDTH_DEF,
   parameter int IW    = cnt_w(ROW)
) (
   input  logic [ROW*width-1:0] buffer,
   input  logic [IW-1:0]        index,
   output logic [width-1:0]     pixel
);

   logic [width-1:0] cols [ROW];

   for (genvar gi = 0; gi < ROW; gi++) begin : g_col
      assign cols[gi] = buffer[(ROW-1-gi)*width +: width];
   end

   assign pixel = cols[index];

endmodule

// File: rtl/row_serializer.sv
// Accepts one packed row at a time and streams its pixels out with valid/ready,
// tracking column/row position across a frame; waits in DONE for a restart.
module row_serializer
   import row_serializer_pkg::*;
#(
   parameter int ROW   = ROW_DEF,
   parameter int COL   = COL_DEF,
   parameter int width = WIDTH_DEF
) (
   input  logic                     CLK,
   input  logic                     SET,
   input  logic                     RST,
   input  logic [ROW*width-1:0]     row_in,
   input  logic                     row_valid,
   output logic                     row_ready,
   output logic [width-1:0]         pix_out,
   output logic                     pix_valid,
   input  logic                     pix_ready,
   output logic [cnt_w(ROW)-1:0]    pix_col,
   output logic [cnt_w(COL)-1:0]    pix_row,
   output logic                     frame_done
);

   localparam int CW = cnt_w(ROW);
   localparam int RW = cnt_w(COL);
   localparam logic [CW-1:0] COL_LAST = CW'(ROW - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(COL - 1);

   rs_state_e              state_q;
   logic [ROW*width-1:0]   buf_q;
   logic [CW-1:0]          col_q;
   logic [RW-1:0]          row_q;
   logic                   row_ready_q;
   logic                   pix_valid_q;
   logic                   frame_done_q;

   // Handshake flags are registered from the next state, so they are valid
   // for the whole cycle the state is held.
   always_ff @(posedge CLK or negedge SET) begin
      if (!SET) begin
         state_q      <= IDLE;
         buf_q        <= '0;
         col_q        <= '0;
         row_q        <= '0;
         row_ready_q  <= 1'b0;
         pix_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (row_valid && row_ready_q) begin
                  buf_q       <= row_in;
                  col_q       <= '0;
                  state_q     <= SHIFT;
                  row_ready_q <= 1'b0;
                  pix_valid_q <= 1'b1;
               end else begin
                  row_ready_q <= 1'b1;
               end
            end
            SHIFT: begin
               if (pix_ready) begin
                  if (col_q != COL_LAST) begin
                     col_q <= col_q + 1'b1;
                  end else if (row_q != ROW_LAST) begin
                     col_q       <= '0;
                     row_q       <= row_q + 1'b1;
                     state_q     <= IDLE;
                     pix_valid_q <= 1'b0;
                     row_ready_q <= 1'b1;
                  end else begin
                     state_q      <= DONE;
                     pix_valid_q  <= 1'b0;
                     frame_done_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (!RST) begin
                  col_q        <= '0;
                  row_q        <= '0;
                  state_q      <= IDLE;
                  frame_done_q <= 1'b0;
                  row_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q      <= IDLE;
               row_ready_q  <= 1'b0;
               pix_valid_q  <= 1'b0;
               frame_done_q <= 1'b0;
            end
         endcase
      end
   end

   pixel_select #(
      .ROW   (ROW),
      .width (width),
      .IW    (CW)
   ) u_pixel_select (
      .buffer (buf_q),
      .index  (col_q),
      .pixel  (pix_out)
   );

   assign row_ready  = row_ready_q;
   assign pix_valid  = pix_valid_q;
   assign frame_done = frame_done_q;
   assign pix_col    = col_q;
   assign pix_row    = row_q;

endmodule

// File: tb/tb_row_serializer.sv
// Directed + randomized bench for row_serializer (ROW=4, COL=3, width=8) with a
// queue-based model of the expected pixel stream.
module tb_row_serializer;

   localparam int ROW = 4;
   localparam int COL = 3;
   localparam int W   = 8;

   logic             CLK = 1'b0;
   logic             SET = 1'b0;
   logic             RST = 1'b1;
   logic [ROW*W-1:0] row_in = '0;
   logic             row_valid = 1'b0;
   logic             pix_ready = 1'b0;
   logic             row_ready;
   logic             pix_valid;
   logic             frame_done;
   logic [W-1:0]     pix_out;
   logic [1:0]       pix_col;
   logic [1:0]       pix_row;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      int r;
      int c;
      int p;
   } pix_t;

   pix_t exp_q[$];
   int   rows_taken = 0;

   always #5 CLK = ~CLK;

   row_serializer #(
      .ROW   (ROW),
      .COL   (COL),
      .width (W)
   ) dut (
      .CLK        (CLK),
      .SET        (SET),
      .RST        (RST),
      .row_in     (row_in),
      .row_valid  (row_valid),
      .row_ready  (row_ready),
      .pix_out    (pix_out),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_col    (pix_col),
      .pix_row    (pix_row),
      .frame_done (frame_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      SET = 1'b0; RST = 1'b1; pix_ready = 1'b0; row_valid = 1'b0;
      @(negedge CLK);
      chk("rst_row_ready",  32'(row_ready),  32'd0);
      chk("rst_pix_valid",  32'(pix_valid),  32'd0);
      chk("rst_frame_done", 32'(frame_done), 32'd0);
      chk("rst_pix_out",    32'(pix_out),    32'd0);
      chk("rst_pix_col",    32'(pix_col),    32'd0);
      chk("rst_pix_row",    32'(pix_row),    32'd0);
      SET = 1'b1;
      exp_q.delete();
      rows_taken = 0;
      @(negedge CLK);
      chk("ready_after_reset", 32'(row_ready), 32'd1);
   endtask

   // Offer a row until it is accepted; the model records its pixels in column order.
   task automatic send_row(input logic [ROW*W-1:0] d);
      int n = 0;
      logic [ROW*W-1:0] t;
      row_in = d; row_valid = 1'b1;
      while (row_ready !== 1'b1 && n < 20) begin
         @(negedge CLK);
         n++;
      end
      chk("accept_timeout", 32'(n < 20), 32'd1);
      if (n < 20) begin
         for (int c = 0; c < ROW; c++) begin
            t = d >> ((ROW - 1 - c) * W);
            exp_q.push_back('{rows_taken, c, int'(t[W-1:0])});
         end
         rows_taken++;
      end
      @(negedge CLK);
      row_valid = 1'b0;
      chk("latency_valid", 32'(pix_valid), 32'(n < 20));
   endtask

   // Consume the expected pixels; junk rows and RST toggles are thrown at the DUT meanwhile.
   task automatic drain(input int pct, input int stall_col, input int stall_len);
      int n = 0;
      int stalls = stall_len;
      while (exp_q.size() > 0 && n < 200) begin
         chk("pix_valid", 32'(pix_valid), 32'd1);
         if (pix_valid === 1'b1) begin
            chk("pix_out", 32'(pix_out), 32'(exp_q[0].p));
            chk("pix_col", 32'(pix_col), 32'(exp_q[0].c));
            chk("pix_row", 32'(pix_row), 32'(exp_q[0].r));
         end
         if (exp_q[0].c == stall_col && stalls > 0) begin
            pix_ready = 1'b0;
            stalls--;
         end else begin
            pix_ready = ($urandom_range(99) < pct);
         end
         row_valid = 1'($urandom_range(1));
         row_in    = (ROW*W)'($urandom);
         RST       = 1'($urandom_range(1));
         if (pix_ready && pix_valid === 1'b1) void'(exp_q.pop_front());
         @(negedge CLK);
         n++;
      end
      pix_ready = 1'b0; row_valid = 1'b0; RST = 1'b1;
      chk("drain_timeout", 32'(n < 200), 32'd1);
      if (n >= 200) exp_q.delete();
      chk("idle_pix_valid",  32'(pix_valid),  32'd0);
      chk("end_frame_done",  32'(frame_done), 32'(rows_taken == COL));
      chk("end_row_ready",   32'(row_ready),  32'(rows_taken != COL));
   endtask

   // Hold DONE with row_valid asserted, then restart with a single RST pulse.
   task automatic done_phase();
      row_valid = 1'b1;
      row_in    = (ROW*W)'($urandom);
      repeat (5) begin
         chk("done_frame_done", 32'(frame_done), 32'd1);
         chk("done_row_ready",  32'(row_ready),  32'd0);
         chk("done_pix_valid",  32'(pix_valid),  32'd0);
         @(negedge CLK);
      end
      row_valid = 1'b0;
      RST = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      chk("restart_row_ready",  32'(row_ready),  32'd1);
      chk("restart_frame_done", 32'(frame_done), 32'd0);
      chk("restart_pix_row",    32'(pix_row),    32'd0);
      chk("restart_pix_col",    32'(pix_col),    32'd0);
      chk("restart_pix_valid",  32'(pix_valid),  32'd0);
      rows_taken = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      do_reset();

      // Basic row, a stalled row, and a third row that completes the frame.
      send_row(32'hA1B2C3D4);
      drain(100, -1, 0);
      send_row(32'h01020304);
      drain(100, 2, 3);
      send_row(32'($urandom));
      drain(100, -1, 0);
      done_phase();

      // Randomized backpressure over a full frame.
      for (int r = 0; r < COL; r++) begin
         send_row(32'($urandom));
         drain(60, int'($urandom_range(3)), int'($urandom_range(3)));
      end
      done_phase();

      // Asynchronous reset in the middle of row 1.
      send_row(32'($urandom));
      drain(100, -1, 0);
      send_row(32'h55667788);
      pix_ready = 1'b1;
      @(negedge CLK);
      pix_ready = 1'b0;
      chk("pre_abort_col", 32'(pix_col), 32'd1);
      chk("pre_abort_row", 32'(pix_row), 32'd1);
      #2 SET = 1'b0;
      #1;
      chk("async_pix_valid",  32'(pix_valid),  32'd0);
      chk("async_row_ready",  32'(row_ready),  32'd0);
      chk("async_pix_col",    32'(pix_col),    32'd0);
      chk("async_pix_row",    32'(pix_row),    32'd0);
      chk("async_pix_out",    32'(pix_out),    32'd0);
      chk("async_frame_done", 32'(frame_done), 32'd0);
      @(negedge CLK);
      SET = 1'b1;
      exp_q.delete();
      rows_taken = 0;
      @(negedge CLK);
      chk("abort_row_ready", 32'(row_ready), 32'd1);
      chk("abort_pix_valid", 32'(pix_valid), 32'd0);
      send_row(32'hFFEE0011);
      drain(100, -1, 0);
      for (int r = 1; r < COL; r++) begin
         send_row(32'($urandom));
         drain(75, int'($urandom_range(3)), int'($urandom_range(2)));
      end
      done_phase();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
